// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory handshake bundle around the port arbiter
interface mem_port_arbiter_if;
    logic        i_start;
    logic        i_ready;
    logic [31:0] i_addr;
    logic        i_flush;
    logic [31:0] i_rdata;
    logic        i_rdata_valid;
    logic        d_start;
    logic        d_write;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_wmask;
    logic [31:0] d_rdata;
    logic        d_rdata_valid;
    logic        m_start;
    logic        m_write;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_wmask;
    logic [31:0] m_rdata;
    logic        m_rdata_valid;
    logic        err_spurious;

    // slave: the arbiter itself; master: the core and memory surrounding it
    modport slave (
        input  i_start, i_addr, i_flush,
        input  d_start, d_write, d_addr, d_wdata, d_wmask,
        input  m_ready, m_rdata, m_rdata_valid,
        output i_ready, i_rdata, i_rdata_valid,
        output d_ready, d_rdata, d_rdata_valid,
        output m_start, m_write, m_addr, m_wdata, m_wmask,
        output err_spurious
    );

    modport master (
        output i_start, i_addr, i_flush,
        output d_start, d_write, d_addr, d_wdata, d_wmask,
        output m_ready, m_rdata, m_rdata_valid,
        input  i_ready, i_rdata, i_rdata_valid,
        input  d_ready, d_rdata, d_rdata_valid,
        input  m_start, m_write, m_addr, m_wdata, m_wmask,
        input  err_spurious
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data ports
// One read outstanding at a time; read data is routed back to whichever side issued it.
module mem_port_arbiter #(
    parameter int DATA_PRIORITY = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    localparam logic [2:0] LIMIT     = (STARVE_LIMIT > 7) ? 3'd7 : 3'(STARVE_LIMIT);
    localparam bit         STARVE_ON = (STARVE_LIMIT != 0);
    localparam bit         DATA_WINS = (DATA_PRIORITY != 0);

    state_t     state;
    logic       squash;
    logic [2:0] cnt_i;
    logic [2:0] cnt_d;
    logic       err_q;

    logic cand_i, cand_d, forced_i, forced_d;
    logic gnt_i, gnt_d, acc_i, acc_d;

    assign cand_i   = bus.i_start && !bus.i_flush;
    assign cand_d   = bus.d_start;
    assign forced_i = STARVE_ON && (cnt_i >= LIMIT);
    assign forced_d = STARVE_ON && (cnt_d >= LIMIT);

    // Grant is gated by rst_n so nothing handshakes while reset is held.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (state == IDLE && rst_n) begin
            if (cand_i && cand_d) begin
                if (forced_i != forced_d) gnt_d = forced_d;
                else                      gnt_d = DATA_WINS;
                gnt_i = !gnt_d;
            end else begin
                gnt_i = cand_i;
                gnt_d = cand_d;
            end
        end
    end

    assign acc_i = gnt_i && bus.m_ready;
    assign acc_d = gnt_d && bus.m_ready;

    assign bus.m_start = gnt_i || gnt_d;
    assign bus.m_write = gnt_d && bus.d_write;
    assign bus.m_addr  = gnt_d ? bus.d_addr  : bus.i_addr;
    assign bus.m_wdata = gnt_d ? bus.d_wdata : 32'd0;
    assign bus.m_wmask = gnt_d ? bus.d_wmask : 32'd0;
    assign bus.i_ready = acc_i;
    assign bus.d_ready = acc_d;

    assign bus.i_rdata       = bus.m_rdata;
    assign bus.d_rdata       = bus.m_rdata;
    assign bus.d_rdata_valid = rst_n && bus.m_rdata_valid && (state == D_WAIT);
    assign bus.i_rdata_valid = rst_n && bus.m_rdata_valid && (state == I_WAIT)
                               && !squash && !bus.i_flush;
    assign bus.err_spurious  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            squash <= 1'b0;
            cnt_i  <= 3'd0;
            cnt_d  <= 3'd0;
            err_q  <= 1'b0;
        end else begin
            // Starvation counters: a waiting loser counts the other side's accepts.
            if (!bus.i_start || acc_i)     cnt_i <= 3'd0;
            else if (cand_i && acc_d)      cnt_i <= (cnt_i == 3'd7) ? cnt_i : cnt_i + 3'd1;
            if (!bus.d_start || acc_d)     cnt_d <= 3'd0;
            else if (cand_d && acc_i)      cnt_d <= (cnt_d == 3'd7) ? cnt_d : cnt_d + 3'd1;

            case (state)
                IDLE: begin
                    squash <= 1'b0;
                    if (bus.m_rdata_valid)          err_q <= 1'b1;
                    if (acc_d && !bus.d_write)      state <= D_WAIT;
                    else if (acc_i)                 state <= I_WAIT;
                end
                I_WAIT: begin
                    if (bus.m_rdata_valid) begin
                        state  <= IDLE;
                        squash <= 1'b0;
                    end else if (bus.i_flush) begin
                        squash <= 1'b1;
                    end
                end
                D_WAIT: begin
                    if (bus.m_rdata_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized check of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int PRIO = 1;
    localparam int LIM  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.DATA_PRIORITY(PRIO), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: who owns the single pending read (0 none, 1 fetch, 2 data),
    // whether its data is to be dropped, and how many times each side has lost.
    int owner = 0;
    bit dropped = 0;
    int lost_i = 0, lost_d = 0;
    bit err_m = 0;
    int mem_cnt = 0;
    bit last_acc_i, last_acc_d;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; dropped = 0; lost_i = 0; lost_d = 0; err_m = 0; mem_cnt = 0;
    endtask

    task automatic step();
        bit ci, cd, fi, fd, wi, wd, ai, ad, mrv, rd;
        @(negedge clk);
        ci  = bus.i_start && !bus.i_flush;
        cd  = bus.d_start;
        mrv = bus.m_rdata_valid;
        fi  = (LIM != 0) && (lost_i >= LIM);
        fd  = (LIM != 0) && (lost_d >= LIM);
        wi = 0; wd = 0;
        if (owner == 0) begin
            if (ci && cd) begin
                if (fi && !fd)      wi = 1;
                else if (fd && !fi) wd = 1;
                else if (PRIO != 0) wd = 1;
                else                wi = 1;
            end else begin
                wi = ci; wd = cd;
            end
        end
        ai = wi && bus.m_ready;
        ad = wd && bus.m_ready;
        check_eq("m_start", bus.m_start, wi || wd);
        check_eq("i_ready", bus.i_ready, ai);
        check_eq("d_ready", bus.d_ready, ad);
        if (wi || wd) begin
            check_eq("m_addr",  bus.m_addr,  wd ? bus.d_addr : bus.i_addr);
            check_eq("m_write", bus.m_write, wd && bus.d_write);
            check_eq("m_wmask", bus.m_wmask, wd ? bus.d_wmask : 32'd0);
            if (wd) check_eq("m_wdata", bus.m_wdata, bus.d_wdata);
        end
        check_eq("i_rdata_valid", bus.i_rdata_valid, mrv && owner == 1 && !dropped && !bus.i_flush);
        check_eq("d_rdata_valid", bus.d_rdata_valid, mrv && owner == 2);
        if (mrv) begin
            check_eq("i_rdata", bus.i_rdata, bus.m_rdata);
            check_eq("d_rdata", bus.d_rdata, bus.m_rdata);
        end
        check_eq("err_spurious", bus.err_spurious, err_m);

        if (mrv && owner == 0) err_m = 1;
        if (!bus.i_start || ai)  lost_i = 0;
        else if (ci && ad)       lost_i = (lost_i < 7) ? lost_i + 1 : 7;
        if (!bus.d_start || ad)  lost_d = 0;
        else if (cd && ai)       lost_d = (lost_d < 7) ? lost_d + 1 : 7;
        rd = ai || (ad && !bus.d_write);
        if (owner == 0) begin
            if (ad && !bus.d_write) owner = 2;
            else if (ai)            owner = 1;
            dropped = 0;
        end else if (mrv) begin
            owner = 0; dropped = 0;
        end else if (owner == 1 && bus.i_flush) begin
            dropped = 1;
        end
        last_acc_i = ai;
        last_acc_d = ad;

        @(posedge clk);
        #1;
        bus.m_rdata_valid = 1'b0;
        if (rd) mem_cnt = $urandom_range(1, 3);
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.m_rdata_valid = 1'b1;
                bus.m_rdata = $urandom;
            end
        end
    endtask

    task automatic drain();
        int k;
        bus.i_start = 0; bus.d_start = 0; bus.i_flush = 0;
        k = 0;
        while ((owner != 0 || mem_cnt != 0 || bus.m_rdata_valid) && k < 20) begin
            step();
            k++;
        end
        step();
        check_eq("drain_idle", owner, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_i_ready"}, bus.i_ready, 0);
        check_eq({tag, "_d_ready"}, bus.d_ready, 0);
        check_eq({tag, "_m_start"}, bus.m_start, 0);
        check_eq({tag, "_i_rvalid"}, bus.i_rdata_valid, 0);
        check_eq({tag, "_d_rvalid"}, bus.d_rdata_valid, 0);
        check_eq({tag, "_err"}, bus.err_spurious, 0);
    endtask

    initial begin
        int n;
        bit got;
        bus.i_start = 0; bus.i_addr = 0; bus.i_flush = 0;
        bus.d_start = 0; bus.d_write = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wmask = 0;
        bus.m_ready = 0; bus.m_rdata = 0; bus.m_rdata_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        bus.i_start = 1; bus.d_start = 1; bus.m_ready = 1;
        #1;
        check_reset_outputs("reset");
        bus.i_start = 0; bus.d_start = 0;
        rst_n = 1'b1;

        // Fetch read of 0x100 returning 0xDEADBEEF
        bus.i_start = 1; bus.i_addr = 32'h100;
        step();
        check_eq("fetch_accept", last_acc_i, 1);
        bus.i_start = 0;
        mem_cnt = 0;
        step();
        bus.m_rdata = 32'hDEADBEEF; bus.m_rdata_valid = 1;
        #1;
        check_eq("fetch_data", bus.i_rdata, 32'hDEADBEEF);
        check_eq("fetch_strobe", bus.i_rdata_valid, 1);
        step();
        drain();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!bus.i_start || last_acc_i) begin
                bus.i_start = ($urandom_range(0, 99) < 60);
                bus.i_addr  = $urandom;
            end
            if (!bus.d_start || last_acc_d) begin
                bus.d_start = ($urandom_range(0, 99) < 60);
                bus.d_write = $urandom_range(0, 1);
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
                bus.d_wmask = $urandom;
            end
            bus.i_flush = ($urandom_range(0, 99) < 10);
            bus.m_ready = ($urandom_range(0, 99) < 75);
        end
        drain();

        // Starvation: back-to-back data writes against a held fetch
        bus.m_ready = 1;
        bus.i_start = 1; bus.i_addr = 32'h300;
        bus.d_start = 1; bus.d_write = 1; bus.d_addr = 32'h40;
        bus.d_wdata = 32'h12345678; bus.d_wmask = 32'h0000FFFF;
        n = 0; got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (last_acc_i) got = 1;
            else if (last_acc_d) begin
                n++;
                bus.d_addr = bus.d_addr + 4;
            end
        end
        check_eq("starve_grant", got, 1);
        check_eq("starve_accepts", n, 4);
        drain();

        // Spurious read data while idle
        bus.m_rdata_valid = 1; bus.m_rdata = 32'hBADBAD00;
        step();
        #1;
        check_eq("spurious_sticky", bus.err_spurious, 1);
        step();

        // Reset in the middle of a data read
        bus.d_start = 1; bus.d_write = 0; bus.d_addr = 32'h200; bus.m_ready = 1;
        step();
        check_eq("d_read_accept", last_acc_d, 1);
        mem_cnt = 0; bus.m_rdata_valid = 0;
        bus.i_start = 1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        bus.i_start = 0; bus.d_start = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.m_rdata_valid = 1;
        step();
        step();
        check_eq("late_data_err", err_m, 1);
        bus.i_start = 1; bus.i_addr = 32'h500;
        step();
        check_eq("post_reset_fetch", last_acc_i, 1);
        bus.i_start = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
